// File: rtl/alu_stim_checker.sv
// Exhaustive ALU sweep: drives every {func,b,a} vector, waits for the ALU to settle,
// and compares its result against a built-in reference model.
module alu_stim_checker #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] alu_ledr,
  output logic [15:0] alu_sw,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic [10:0] first_fail
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t      state;
  logic [10:0] idx;
  logic [3:0]  cnt;

  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] func;
  logic [4:0] sum5;
  logic [4:0] diff5;
  logic [9:0] expected;
  logic [9:0] mask;
  logic       mismatch;
  logic       unused_ledr;

  assign a      = idx[3:0];
  assign b      = idx[7:4];
  assign func   = idx[10:8];
  assign alu_sw = {5'b0, idx};

  // Upper result bits carry nothing checkable; they are folded away on purpose.
  assign unused_ledr = ^alu_ledr[15:10];

  always_comb begin
    sum5     = {1'b0, a} + {1'b0, b};
    diff5    = {1'b0, a} + {1'b0, ~b} + 5'd1;
    expected = '0;
    mask     = '0;
    case (func)
      3'd0: begin
        expected[3:0] = sum5[3:0];
        expected[4]   = sum5[4];
        expected[5]   = (a[3] == b[3]) && (sum5[3] != a[3]);
        mask          = 10'h3FF;
      end
      3'd1: begin
        expected[3:0] = diff5[3:0];
        expected[4]   = diff5[4];
        expected[5]   = (a[3] != b[3]) && (diff5[3] != a[3]);
        mask          = 10'h3FF;
      end
      3'd2: begin
        expected[9:6] = ~a;
        mask          = 10'h3C0;
      end
      3'd3: begin
        expected[9:6] = a & b;
        mask          = 10'h3C0;
      end
      3'd4: begin
        expected[9:6] = a | b;
        mask          = 10'h3C0;
      end
      3'd5: begin
        expected[9:6] = a ^ b;
        mask          = 10'h3C0;
      end
      3'd6: begin
        expected[6] = $signed(a) < $signed(b);
        mask        = 10'h040;
      end
      default: begin
        expected[6] = (a == b);
        mask        = 10'h040;
      end
    endcase
  end

  // Masking before the reduction keeps X on don't-care bits out of the count.
  assign mismatch = |((alu_ledr[9:0] ^ expected) & mask);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx        <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            cnt        <= RELOAD;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == 4'd0) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            if (err_cnt == 8'd0) begin
              first_fail <= idx;
            end
          end
          if (idx == 11'h7FF) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            idx   <= idx + 11'd1;
            cnt   <= RELOAD;
            state <= S_SETTLE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          pass  <= (err_cnt == 8'd0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stim_checker.sv
// Sweep-level bench: a behavioural ALU (with selectable faults) sits on the switch bus,
// and a done-driven monitor scores each sweep against hand-computed outcomes.
module tb_alu_stim_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] alu_ledr;
  logic [15:0] alu_sw;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_cnt;
  logic [10:0] first_fail;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_done = 0;
  int          mode = 0;
  logic [15:0] noise = 16'h0;
  logic        done_seen = 1'b0;

  typedef struct {
    logic        pass;
    logic [7:0]  err;
    logic [10:0] ff;
    int          gap;
    logic        from_prev;
  } exp_t;

  exp_t sb[$];

  alu_stim_checker #(.SETTLE(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .alu_ledr   (alu_ledr),
    .alu_sw     (alu_sw),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) noise <= 16'($urandom);

  // Mode 0 golden, 1 sum[0] stuck low, 2 unsigned compare on func 110, 3 noise on don't-care bits.
  always @* begin : alu_model
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] fn;
    int         sa;
    int         sbv;
    int         r;
    a   = alu_sw[3:0];
    b   = alu_sw[7:4];
    fn  = alu_sw[10:8];
    sa  = a[3] ? int'(a) - 16 : int'(a);
    sbv = b[3] ? int'(b) - 16 : int'(b);
    r   = 0;
    alu_ledr = 16'h0;
    case (fn)
      3'd0: begin
        r = int'(a) + int'(b);
        alu_ledr[3:0] = 4'(r);
        alu_ledr[4]   = (r > 15);
        alu_ledr[5]   = (sa + sbv > 7) || (sa + sbv < -8);
      end
      3'd1: begin
        r = int'(a) - int'(b);
        alu_ledr[3:0] = 4'(r);
        alu_ledr[4]   = (a >= b);
        alu_ledr[5]   = (sa - sbv > 7) || (sa - sbv < -8);
      end
      3'd2: alu_ledr[9:6] = ~a;
      3'd3: alu_ledr[9:6] = a & b;
      3'd4: alu_ledr[9:6] = a | b;
      3'd5: alu_ledr[9:6] = a ^ b;
      3'd6: alu_ledr[6] = (mode == 2) ? (a < b) : (sa < sbv);
      default: alu_ledr[6] = (a == b);
    endcase
    if (mode == 1) alu_ledr[0] = 1'b0;
    if (mode == 3) begin
      alu_ledr[15:10] = noise[15:10];
      if (fn >= 3'd2) alu_ledr[5:0] = noise[5:0];
      if (fn >= 3'd6) alu_ledr[9:7] = noise[9:7] | 3'b001;
    end
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (done_seen) check("done_width", 32'(done), 32'd0);
    done_seen = 1'b0;
    if (rst && done === 1'b1) begin
      done_seen = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pass", 32'(pass), 32'(e.pass));
        check("err_cnt", 32'(err_cnt), 32'(e.err));
        check("first_fail", 32'(first_fail), 32'(e.ff));
        check("done_cycle", 32'(e.from_prev ? cyc - last_done : cyc - start_cyc), 32'(e.gap));
      end
      last_done = cyc;
    end
  end

  task automatic push_exp(logic p, logic [7:0] e, logic [10:0] f, int gap, logic from_prev);
    exp_t x;
    x.pass = p;
    x.err = e;
    x.ff = f;
    x.gap = gap;
    x.from_prev = from_prev;
    sb.push_back(x);
  endtask

  task automatic apply_stimulus(int m, logic p, logic [7:0] e, logic [10:0] f);
    mode = m;
    push_exp(p, e, f, 6145, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    check("busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_queue(int target, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() <= target) break;
    end
    @(negedge clk);
    if (sb.size() > target) begin
      check("sweep_timeout", 32'(sb.size()), 32'(target));
      sb.delete();
    end
  endtask

  task automatic check_output(logic p, logic [7:0] e, logic [10:0] f);
    repeat (5) @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
    check("pass_hold", 32'(pass), 32'(p));
    check("err_cnt_hold", 32'(err_cnt), 32'(e));
    check("first_fail_hold", 32'(first_fail), 32'(f));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_alu_sw", 32'(alu_sw), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_first_fail", 32'(first_fail), 32'd0);
    rst = 1'b1;

    apply_stimulus(0, 1'b1, 8'd0, 11'h000);
    wait_queue(0, 7000);
    check_output(1'b1, 8'd0, 11'h000);

    apply_stimulus(1, 1'b0, 8'd255, 11'h001);
    wait_queue(0, 7000);
    check_output(1'b0, 8'd255, 11'h001);

    apply_stimulus(2, 1'b0, 8'd128, 11'h608);
    wait_queue(0, 7000);
    check_output(1'b0, 8'd128, 11'h608);

    apply_stimulus(3, 1'b1, 8'd0, 11'h000);
    wait_queue(0, 7000);
    check_output(1'b1, 8'd0, 11'h000);

    // Abort a sweep asynchronously, then restart on the first edge after release.
    apply_stimulus(0, 1'b1, 8'd0, 11'h000);
    repeat (98) @(negedge clk);
    start = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("abort_alu_sw", 32'(alu_sw), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("abort_pass", 32'(pass), 32'd0);
    push_exp(1'b1, 8'd0, 11'h000, 6145, 1'b0);
    @(posedge clk);
    #1 start_cyc = cyc;
    check("restart_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_queue(0, 7000);
    check_output(1'b1, 8'd0, 11'h000);

    // Start held high: the second sweep must follow with no extra DONE-cycle latch.
    push_exp(1'b1, 8'd0, 11'h000, 6145, 1'b0);
    push_exp(1'b1, 8'd0, 11'h000, 6146, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    repeat (500) @(negedge clk);
    check("held_start_busy", 32'(busy), 32'd1);
    wait_queue(1, 7000);
    repeat (2) @(negedge clk);
    start = 1'b0;
    check("second_sweep_busy", 32'(busy), 32'd1);
    wait_queue(0, 7000);
    check_output(1'b1, 8'd0, 11'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
